// File: rtl/input_port_buffer.sv
// Router input port: flit FIFO plus a per-flit route-compute / switch-allocation sequencer.
// Each head flit walks IDLE -> RC -> RC_WAIT -> REQ and pops when the allocator grants it.
module input_port_buffer #(
    parameter int FLIT_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [FLIT_W-1:0]          in_data,
    output logic                       in_ready,
    output logic                       rc_en,
    output logic [2:0]                 rc_dst,
    input  logic [2:0]                 rc_port,
    output logic                       sa_req,
    output logic [2:0]                 sa_port,
    output logic [FLIT_W-1:0]          sa_data,
    input  logic                       sa_grant,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        RC,
        RC_WAIT,
        REQ
    } state_t;

    state_t              state;
    logic [FLIT_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [2:0]          port_reg;
    logic [FLIT_W-1:0]   head;
    logic                push;
    logic                pop;

    // Readiness comes only from the registered count, so a full FIFO refuses a
    // write even in the cycle its head is being granted.
    assign in_ready  = (count < CNT_W'(DEPTH));
    assign push      = in_valid && in_ready;
    assign pop       = (state == REQ) && sa_grant;
    assign head      = mem[rd_ptr];
    assign occupancy = count;
    assign sa_port   = port_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally at their width.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // The head only changes on a pop, which happens solely in REQ, so the flit
    // sampled for rc_dst is the same one later latched onto sa_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rc_en    <= 1'b0;
            rc_dst   <= 3'b000;
            sa_req   <= 1'b0;
            sa_data  <= '0;
            port_reg <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state  <= RC;
                        rc_en  <= 1'b1;
                        rc_dst <= head[FLIT_W-1 -: 3];
                    end
                end
                RC: begin
                    state <= RC_WAIT;
                    rc_en <= 1'b0;
                end
                RC_WAIT: begin
                    state    <= REQ;
                    port_reg <= rc_port;
                    sa_req   <= 1'b1;
                    sa_data  <= head;
                end
                REQ: begin
                    if (sa_grant) begin
                        state   <= IDLE;
                        sa_req  <= 1'b0;
                        sa_data <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    rc_en <= 1'b0;
                    sa_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
